// File: rtl/mux_nx1_rr.sv
// N-input registered multiplexer with per-channel valid/ready, selectable
// fixed-select or round-robin arbitration, and a single registered output stage.
module mux_nx1_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]  ch_data [N];
  logic          load;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic [SW:0]   rr_idx;

  logic [W-1:0]  out_data_reg, out_data_next;
  logic [SW-1:0] out_ch_reg, out_ch_next;
  logic          out_valid_reg, out_valid_next;
  logic [SW-1:0] ptr_reg, ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*W +: W];
      // Gated by rst_n so no channel is acknowledged while the block is held in reset.
      assign in_ready[gi] = rst_n & load & grant_found & (grant_idx == SW'(gi));
    end
  endgenerate

  assign load = !out_valid_reg | out_ready;

  // Fixed mode looks only at the selected channel's valid; rr scans from ptr with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    if (!mode) begin
      if (int'(sel) < N) begin
        grant_found = in_valid[sel];
        grant_idx   = sel;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rr_idx = {1'b0, ptr_reg} + (SW+1)'(i);
        if (rr_idx >= (SW+1)'(N)) rr_idx = rr_idx - (SW+1)'(N);
        if (!grant_found && in_valid[rr_idx[SW-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = rr_idx[SW-1:0];
        end
      end
    end
  end

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    ptr_next       = ptr_reg;
    if (load) begin
      out_valid_next = grant_found;
      if (grant_found) begin
        out_data_next = ch_data[grant_idx];
        out_ch_next   = grant_idx;
        if (mode) ptr_next = (grant_idx == SW'(N-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      ptr_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: table of per-cycle vectors with a scoreboard of expected
// output words, plus hand-written sequences for N=3 out-of-range and async reset.
module tb_mux_nx1_rr;

  localparam logic [31:0] CH_DATA  = {8'hC3, 8'hA5, 8'h3C, 8'h11};
  localparam logic [23:0] CH_DATA3 = {8'h77, 8'h66, 8'h55};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        mode, out_ready, out_valid;
  logic [1:0]  sel, out_ch;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;

  logic        mode3, out_ready3, out_valid3;
  logic [1:0]  sel3, out_ch3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;

  mux_nx1_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nx1_rr #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_rdy;
  } vec_t;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } word_t;

  localparam int NV = 34;
  vec_t  vecs [NV];
  word_t sb [$];
  logic  exp_ov;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered at posedge+1: drive, sample at posedge+5, then advance one clock.
  task automatic cycle4(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic r, input logic [3:0] er, input int id);
    word_t w;
    mode = m; sel = s; in_valid = v; out_ready = r;
    #4;
    chk($sformatf("v%0d out_valid", id), out_valid, exp_ov);
    if (out_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL v%0d unexpected word: got ch=%0d data=%0h, expected none", id, out_ch, out_data);
      end else begin
        chk($sformatf("v%0d out_ch", id), out_ch, sb[0].ch);
        chk($sformatf("v%0d out_data", id), out_data, sb[0].data);
        if (r) void'(sb.pop_front());
      end
    end
    chk($sformatf("v%0d in_ready", id), in_ready, er);
    if (!exp_ov || r) begin
      if (er != 4'b0000) begin
        w.ch   = 2'($clog2(er));
        w.data = CH_DATA[int'(w.ch)*8 +: 8];
        sb.push_back(w);
        exp_ov = 1'b1;
      end else begin
        exp_ov = 1'b0;
      end
    end
    @(posedge clk); #1;
    $display("[TB] v%0d mode=%0b sel=%0d valid=%b ready=%b -> in_ready=%b", id, m, s, v, r, er);
  endtask

  initial begin
    //            mode sel  valid    ready exp_rdy
    vecs[0]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[1]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[2]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010};
    vecs[4]  = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[11] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    vecs[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    vecs[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    vecs[14] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    vecs[15] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001};
    vecs[16] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[17] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[18] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[19] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    vecs[20] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[21] = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000};
    vecs[22] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001};
    vecs[23] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[24] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    vecs[25] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000};
    vecs[26] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    vecs[27] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[28] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000};
    vecs[29] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000};
    vecs[30] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000};
    vecs[31] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    vecs[32] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    vecs[33] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};

    in_data  = CH_DATA;
    in_data3 = CH_DATA3;
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b1;
    exp_ov = 1'b0;
    rst_n = 1'b0;

    // Reset with every channel requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 8'h00);
    chk("rst out_ch", out_ch, 2'd0);
    chk("rst in_ready", in_ready, 4'b0000);
    chk("rst in_ready3", in_ready3, 3'b000);
    $display("[TB] reset held with all valid");
    in_valid = 4'b0000; in_valid3 = 3'b000;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      cycle4(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ready, vecs[i].exp_rdy, i);

    // N=3: sel=2 transfers, sel=3 never grants and the held word survives out_valid dropping.
    sel3 = 2'd2; in_valid3 = 3'b111;
    #4 chk("n3 sel2 in_ready", in_ready3, 3'b100);
    @(posedge clk); #1;
    sel3 = 2'd3;
    #4;
    chk("n3 sel3 in_ready", in_ready3, 3'b000);
    chk("n3 word out_valid", out_valid3, 1'b1);
    chk("n3 word out_ch", out_ch3, 2'd2);
    chk("n3 word out_data", out_data3, 8'h77);
    @(posedge clk); #1;
    $display("[TB] n3 fixed sel=3 after sel=2 transfer");
    #4;
    chk("n3 drop out_valid", out_valid3, 1'b0);
    chk("n3 hold out_ch", out_ch3, 2'd2);
    chk("n3 hold out_data", out_data3, 8'h77);
    mode3 = 1'b1; in_valid3 = 3'b100;
    #1 chk("n3 rr ch2 in_ready", in_ready3, 3'b100);
    @(posedge clk); #1;
    in_valid3 = 3'b101;
    #4 chk("n3 rr wrap in_ready", in_ready3, 3'b001);
    @(posedge clk); #1;
    in_valid3 = 3'b000;
    $display("[TB] n3 rr wrap sequence");

    // Async reset mid-stream: after it the rr scan starts again from ch0.
    cycle4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 100);
    #3 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", out_valid, 1'b0);
    chk("mid rst out_data", out_data, 8'h00);
    chk("mid rst out_ch", out_ch, 2'd0);
    chk("mid rst in_ready", in_ready, 4'b0000);
    sb.delete();
    exp_ov = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] async reset mid-stream released");
    cycle4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 101);
    cycle4(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 102);
    cycle4(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 103);
    cycle4(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
